pc_fetch: RTL
=============

# pc_fetch

Program-counter register and instruction-fetch sequencer for the MIPS32 CPU. Holds the current word-aligned PC, drives it back to the next-PC logic as `curPC`, and fetches the instruction at that PC from instruction memory over a req/ack handshake. It presents the fetched word to decode over a valid/ready handshake, and loads the next-PC result only when decode accepts the current instruction. It closes the loop that the combinational next-PC block opens.

## Interface
Parameters:
- `RESET_PC`, 30'h0000_0C00 — word address loaded on reset (byte address 0x0000_3000).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `nPC`  in  30  — next word PC from the next-PC logic.
- `curPC`  out  30  — current word PC, fed to the next-PC logic.
- `stall`  in  1  — hazard stall from control; blocks PC advance.
- `imem_req`  out  1  — fetch request.
- `imem_addr`  out  32  — byte address, `{curPC, 2'b00}`.
- `imem_ack`  in  1  — memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  — fetched instruction word.
- `instr`  out  32  — registered instruction to decode.
- `instr_valid`  out  1  — `instr` is valid.
- `instr_ready`  in  1  — decode accepts `instr`.
- `retired`  out  32  — count of instructions accepted by decode.

## Operation
- FSM states:
  - IDLE: reset state, one cycle only. Next state is FETCH.
  - FETCH: `imem_req` = 1. `imem_addr` is held stable while waiting. On `imem_ack`, capture `imem_rdata` into `instr` and go to VALID.
  - VALID: `instr_valid` = 1. On `instr_ready & !stall`:
    - `curPC <= nPC`
    - `retired <= retired + 1`, wrapping at 2^32
    - go to FETCH.
    Otherwise stay in VALID, with `instr` and `curPC` held.
- `curPC` changes only on the VALID→FETCH transition, so the next-PC logic always sees a stable `curPC` for the whole fetch/decode of the current instruction.
- `nPC` is sampled only at acceptance. Its value in other cycles is don't-care.
- In IDLE, `imem_ack` is ignored. In VALID, `imem_ack` is ignored and `imem_rdata` is not captured.
- `stall` has no effect in FETCH. A request in flight always completes.
- `nPC` is taken as-is (30-bit word PC). No alignment fault is possible.

## Timing
- All outputs are registered or decoded from the registered state only. No input→output combinational path.
- Reset values:
  - `curPC` = `RESET_PC`, `instr` = 0, `retired` = 0
  - state IDLE, so `imem_req` = 0 and `instr_valid` = 0.
- Reset is asserted asynchronously. Release is assumed synchronized upstream. The first rising edge after release moves IDLE→FETCH, so `imem_req` rises in cycle 1.
- Zero-wait memory: ack in the first FETCH cycle makes `instr_valid` high the next cycle. With decode always ready and no stall, one instruction is accepted every 2 cycles.
- N wait cycles before ack adds N cycles of latency.
- Acceptance edge: `curPC` updates and `imem_req` rises the cycle after VALID with `instr_ready & !stall`.
- If reset is asserted mid-fetch, the request is dropped: `imem_req` falls immediately. Memory must tolerate an abandoned request.
- `retired` wraps 0xFFFF_FFFF→0 without a flag.

## Structure
- Shared CPU package:
  - state enum `fetch_state_t` {IDLE, FETCH, VALID}
  - `RESET_PC_DEFAULT` constant
  - `WORD_PC_W` = 30.
- One sub-module: `retire_counter`, a 32-bit enable counter with async active-low clear. Everything else stays in `pc_fetch`.

## Test plan
- Reset, `imem_ack` tied 1, `instr_ready` = 1, `nPC` = `curPC` + 1:
  - `imem_addr` sequence 0x3000, 0x3004, 0x3008
  - `instr_valid` high on every second cycle
  - `retired` = 3 after 6 cycles.
- `imem_ack` delayed 3 cycles:
  - `imem_req` held high 4 cycles with `imem_addr` = 0x3000 constant
  - `instr` = `imem_rdata` sampled at ack (0x2408_0005).
- `stall` = 1 for 5 cycles in VALID, `nPC` changing:
  - `curPC` and `instr` are frozen
  - on release, `curPC` = `nPC` value at the release edge (0x0000_0D10 → `imem_addr` 0x3440).
- `instr_ready` = 0 in VALID while `imem_ack` pulses:
  - `instr` unchanged, `retired` unchanged.
- `rst_n` pulsed low mid-FETCH, with `curPC` = 0x0C05:
  - immediately `imem_req` = 0, `instr_valid` = 0, `curPC` = 0x0C00.
- Preload `retired` to 0xFFFF_FFFF (force), then accept one instruction:
  - `retired` = 0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared CPU definitions for the program-counter / fetch sequencer.
package pc_fetch_pkg;

    localparam int WORD_PC_W = 30;
    localparam logic [WORD_PC_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } fetch_state_t;

endpackage

// File: rtl/retire_counter.sv
// 32-bit enable counter with asynchronous active-low clear; wraps silently.
module retire_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign cnt_d = cnt_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer: fetches at curPC over req/ack,
// hands the word to decode over valid/ready, and loads nPC on acceptance.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [WORD_PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_PC_W-1:0] nPC,
    output logic [WORD_PC_W-1:0] curPC,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          retired
);

    fetch_state_t         state_q;
    logic [WORD_PC_W-1:0] pc_q;
    logic [31:0]          instr_q;
    logic                 req_q;
    logic                 valid_q;
    logic                 accept;

    // Decode takes the instruction; this is the only moment the PC may move.
    assign accept = (state_q == VALID) && instr_ready && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (accept) begin
                        pc_q    <= nPC;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    retire_counter u_retire (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (accept),
        .count_o (retired)
    );

    assign curPC       = pc_q;
    assign imem_addr   = {pc_q, 2'b00};
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule
